// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
// FSM encoding, reset divider and divider clamp helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_ACK  = 2'd2
    } rx_state_e;

    localparam logic [31:0] DEFAULT_CLK_DIV = 32'd434;
    localparam logic [31:0] MIN_CLK_DIV     = 32'd2;

    function automatic logic [31:0] clamp_div(
        input logic [31:0] v
    );
        return (v < MIN_CLK_DIV) ? MIN_CLK_DIV : v;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver, configuration and read-side signals of the UART
// receive controller; slave is the controller, master its environment.
interface uart_rx_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             rx_byte_finish;
    logic [7:0]       rx_data;
    logic             rx_frame_err;
    logic             rx_busy;
    logic             rx_ack;
    logic [31:0]      clk_div;
    logic             cfg_wr;
    logic [31:0]      cfg_clk_div;
    logic             rd_en;
    logic [7:0]       rd_data;
    logic             rd_empty;
    logic [LW-1:0]    rd_level;
    logic [LW-1:0]    irq_thresh;
    logic             status_clr;
    logic             overrun;
    logic [CNT_W-1:0] frame_err_cnt;
    logic             irq;

    modport slave (
        input  rx_byte_finish,
        input  rx_data,
        input  rx_frame_err,
        input  rx_busy,
        output rx_ack,
        output clk_div,
        input  cfg_wr,
        input  cfg_clk_div,
        input  rd_en,
        output rd_data,
        output rd_empty,
        output rd_level,
        input  irq_thresh,
        input  status_clr,
        output overrun,
        output frame_err_cnt,
        output irq
    );

    modport master (
        output rx_byte_finish,
        output rx_data,
        output rx_frame_err,
        output rx_busy,
        input  rx_ack,
        input  clk_div,
        output cfg_wr,
        output cfg_clk_div,
        output rd_en,
        input  rd_data,
        input  rd_empty,
        input  rd_level,
        output irq_thresh,
        output status_clr,
        input  overrun,
        input  frame_err_cnt,
        input  irq
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is
// accepted only when a real pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte capture and acknowledge FSM,
// receive FIFO, divider configuration, error status and interrupt.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int          DEPTH           = 8,
    parameter logic [31:0] DEFAULT_CLK_DIV = uart_pkg::DEFAULT_CLK_DIV,
    parameter int          CNT_W           = 8
) (
    input logic           clk,
    input logic           rst,
    uart_rx_ctrl_if.slave bus
);

    localparam int LW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_rx_ctrl: DEPTH must be a power of two >= 2");
    end

    rx_state_e        state;
    rx_state_e        state_next;
    logic [7:0]       hold;
    logic             hold_load;
    logic             push;
    logic             ovr_set;
    logic             ack;

    logic             fifo_full;
    logic             fifo_empty;
    logic [LW-1:0]    fifo_level;
    logic [7:0]       fifo_dout;

    logic [31:0]      clk_div;
    logic [31:0]      pend_val;
    logic             pend_valid;
    logic             apply;

    logic             overrun;
    logic [CNT_W-1:0] fcnt;
    logic             irq;
    logic             irq_src;

    always_comb begin
        state_next = state;
        hold_load  = 1'b0;
        push       = 1'b0;
        ovr_set    = 1'b0;
        ack        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.rx_byte_finish) begin
                    hold_load  = 1'b1;
                    state_next = ST_PUSH;
                end
            end
            ST_PUSH: begin
                push       = 1'b1;
                ovr_set    = fifo_full && !bus.rd_en;
                state_next = ST_ACK;
            end
            ST_ACK: begin
                ack        = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            hold  <= 8'h00;
        end else begin
            state <= state_next;
            if (hold_load) begin
                hold <= bus.rx_data;
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (hold),
        .pop   (bus.rd_en),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Only retune the receiver between frames with no byte in flight.
    assign apply = pend_valid && !bus.rx_busy && (state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_div    <= DEFAULT_CLK_DIV;
            pend_val   <= DEFAULT_CLK_DIV;
            pend_valid <= 1'b0;
        end else begin
            if (apply) begin
                clk_div <= pend_val;
            end
            if (bus.cfg_wr) begin
                pend_val   <= clamp_div(bus.cfg_clk_div);
                pend_valid <= 1'b1;
            end else if (apply) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            fcnt    <= '0;
        end else begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (bus.status_clr) begin
                overrun <= 1'b0;
            end
            if (bus.rx_frame_err) begin
                if (bus.status_clr) begin
                    fcnt <= CNT_W'(1);
                end else if (fcnt != '1) begin
                    fcnt <= fcnt + 1'b1;
                end
            end else if (bus.status_clr) begin
                fcnt <= '0;
            end
        end
    end

    assign irq_src = ((bus.irq_thresh != '0) &&
                      (fifo_level >= bus.irq_thresh)) ||
                     overrun || (fcnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_src;
        end
    end

    assign bus.rx_ack        = ack;
    assign bus.clk_div       = clk_div;
    assign bus.rd_data       = fifo_dout;
    assign bus.rd_empty      = fifo_empty;
    assign bus.rd_level      = fifo_level;
    assign bus.overrun       = overrun;
    assign bus.frame_err_cnt = fcnt;
    assign bus.irq           = irq;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller for the UART receive datapath. Accepts each completed byte from the receiver, buffers it in a small FIFO, and returns the byte-consumed acknowledge that releases the receiver from its wait-for-read state. It also owns the receiver's bit-period divider configuration, with safe-update rules, and provides error status and a level interrupt. It sits between the receiver and the user-project register/bus interface.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
DEFAULT_CLK_DIV, 32'd434, divider value loaded at reset.
CNT_W, 8, width of the saturating frame-error counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
rx_byte_finish  in  1  one-cycle pulse from receiver: byte ready
rx_data  in  8  receiver data; valid while receiver waits for acknowledge
rx_frame_err  in  1  one-cycle pulse from receiver: bad stop bit
rx_busy  in  1  receiver is mid-frame
rx_ack  out  1  byte-consumed pulse to receiver
clk_div  out  32  divider driven to receiver
cfg_wr  in  1  request a divider update
cfg_clk_div  in  32  new divider value
rd_en  in  1  pop FIFO head
rd_data  out  8  FIFO head, first-word-fall-through
rd_empty  out  1  FIFO empty
rd_level  out  $clog2(DEPTH)+1  occupancy
irq_thresh  in  $clog2(DEPTH)+1  level interrupt threshold; 0 disables
status_clr  in  1  clear sticky status bits
overrun  out  1  sticky: a byte was dropped because the FIFO was full
frame_err_cnt  out  CNT_W  saturating count of frame errors
irq  out  1  registered interrupt

Behaviour:
- Reset values: rx_ack=0, clk_div=DEFAULT_CLK_DIV, rd_empty=1, rd_level=0, rd_data=0, overrun=0, frame_err_cnt=0, irq=0, no divider update pending, FSM=IDLE. Reset is effective at any time, including mid-sequence; rx_ack drops immediately.
- FSM states: IDLE, PUSH, ACK.
  - IDLE: when rx_byte_finish=1, latch rx_data into the hold register and go to PUSH.
  - PUSH: if the FIFO is not full, or rd_en is asserted on a non-empty FIFO in the same cycle, write the hold byte. Otherwise drop the byte and set overrun. Go to ACK.
  - ACK: rx_ack=1 for exactly this one cycle, then IDLE.
- Timing: pulse at cycle T gives the FIFO write at the end of T+1, rx_ack high in T+2, and rd_empty low from T+2.
- rx_byte_finish seen outside IDLE is ignored. The receiver cannot legally issue one before it is acknowledged.
- A byte is always acknowledged, even when dropped, so the receiver never stalls.
- FIFO pops:
  - rd_en on an empty FIFO is ignored.
  - A simultaneous push and pop leaves rd_level unchanged.
  - Pointers wrap modulo DEPTH.
- Frame errors: each rx_frame_err pulse increments frame_err_cnt, saturating at all-ones. No acknowledge is issued for it.
- status_clr clears overrun and frame_err_cnt. If a set/increment event occurs in the same cycle, the event wins: the result is 1 and 1 respectively.
- Divider updates:
  - cfg_wr captures cfg_clk_div into a pending register; values below 2 are clamped to 2.
  - The pending value is applied to clk_div on the first cycle with rx_busy=0 and FSM=IDLE. This may be the cycle right after cfg_wr.
  - A newer cfg_wr overwrites an unapplied pending value.
- irq is registered and asserts one cycle after its source condition: (irq_thresh!=0 and rd_level>=irq_thresh) or overrun or frame_err_cnt!=0.

Decomposition:
- Package uart_pkg: FSM state encoding, DEFAULT_CLK_DIV, minimum divider constant (2).
- One sub-module, uart_rx_fifo: synchronous FWFT FIFO with push, pop, full, empty and level. The controller FSM, config and status logic stay in uart_rx_ctrl.

Test Plan:
- Single byte: rx_byte_finish pulse with rx_data=8'hA5 -> rx_ack single pulse 2 cycles later; rd_data=8'hA5; rd_level=1; rd_en drains to rd_empty=1.
- Overflow: DEPTH=8, 9 bytes 8'h00..8'h08 with no reads -> 9 rx_ack pulses; overrun=1; reads return 00..07; irq=1; status_clr then clears overrun and irq.
- Simultaneous push and pop: FIFO full, rd_en asserted during PUSH -> new byte stored, no overrun, rd_level stays 8.
- Frame errors: 300 rx_frame_err pulses with CNT_W=8 -> frame_err_cnt=255; status_clr in the same cycle as a pulse -> count=1.
- Divider update: cfg_wr of 32'd100 while rx_busy=1 -> clk_div unchanged until rx_busy falls, then 100. A later cfg_wr of 0 -> clk_div=2.
- Reset during ACK: assert rst in the ACK cycle -> rx_ack=0 immediately; FIFO empty; clk_div=DEFAULT_CLK_DIV.
